// File: rtl/nco_pkg.sv
// nco_pkg: shared definitions for the time-multiplexed NCO accumulator.
//   state_e  - scheduler state encoding (IDLE / RUN / DRAIN)
//   ADD_LAT  - issue-to-result latency of the shared pipelined adder
package nco_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned ADD_LAT = 2;

endpackage

// File: rtl/pipe_add.sv
// pipe_add: W-bit two-stage pipelined adder with a valid bit and a tag that
// travel with the operands.
//   Stage 1 registers the operands, stage 2 registers sum and carry.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   flush          drops both pipeline valids at the next edge
//   in_vld/tag/a/b issue side
//   wb_vld/tag/sum the result being loaded into stage 2 at this edge, so the
//                  owner can write its state on the same edge the result
//                  becomes visible
//   out_vld/tag    registered result valid and tag
//   sum, carry     registered result; held while no result completes
module pipe_add #(
  parameter int W  = 16,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_vld,
  input  logic [TW-1:0] in_tag,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          wb_vld,
  output logic [TW-1:0] wb_tag,
  output logic [W-1:0]  wb_sum,
  output logic          out_vld,
  output logic [TW-1:0] out_tag,
  output logic [W-1:0]  sum,
  output logic          carry
);

  logic          vld_p1_q, vld_p1_d;
  logic [TW-1:0] tag_p1_q, tag_p1_d;
  logic [W-1:0]  a_p1_q, a_p1_d;
  logic [W-1:0]  b_p1_q, b_p1_d;
  logic [W:0]    add_p1;

  logic          vld_p2_q, vld_p2_d;
  logic [TW-1:0] tag_p2_q, tag_p2_d;
  logic [W-1:0]  sum_p2_q, sum_p2_d;
  logic          carry_p2_q, carry_p2_d;

  always_comb begin
    // stage 1: operand capture
    vld_p1_d = in_vld && !flush;
    tag_p1_d = tag_p1_q;
    a_p1_d   = a_p1_q;
    b_p1_d   = b_p1_q;
    if (in_vld) begin
      tag_p1_d = in_tag;
      a_p1_d   = in_a;
      b_p1_d   = in_b;
    end

    // stage 2: sum and carry capture; data only moves with a valid result
    add_p1     = {1'b0, a_p1_q} + {1'b0, b_p1_q};
    vld_p2_d   = vld_p1_q && !flush;
    tag_p2_d   = tag_p2_q;
    sum_p2_d   = sum_p2_q;
    carry_p2_d = carry_p2_q;
    if (vld_p2_d) begin
      tag_p2_d   = tag_p1_q;
      sum_p2_d   = add_p1[W-1:0];
      carry_p2_d = add_p1[W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q   <= 1'b0;
      tag_p1_q   <= '0;
      a_p1_q     <= '0;
      b_p1_q     <= '0;
      vld_p2_q   <= 1'b0;
      tag_p2_q   <= '0;
      sum_p2_q   <= '0;
      carry_p2_q <= 1'b0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      tag_p1_q   <= tag_p1_d;
      a_p1_q     <= a_p1_d;
      b_p1_q     <= b_p1_d;
      vld_p2_q   <= vld_p2_d;
      tag_p2_q   <= tag_p2_d;
      sum_p2_q   <= sum_p2_d;
      carry_p2_q <= carry_p2_d;
    end
  end

  assign wb_vld  = vld_p2_d;
  assign wb_tag  = tag_p1_q;
  assign wb_sum  = add_p1[W-1:0];
  assign out_vld = vld_p2_q;
  assign out_tag = tag_p2_q;
  assign sum     = sum_p2_q;
  assign carry   = carry_p2_q;

endmodule

// File: rtl/nco_acc_sched.sv
// nco_acc_sched: NCH time-multiplexed phase accumulators sharing one
// two-stage pipelined adder. In RUN one channel is issued per cycle in
// round-robin order; its updated phase appears two cycles later.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   en                  run request (0 = stop issuing, drain the adder)
//   clr                 synchronous clear of phases, slot and pipeline
//   cfg_valid/cfg_ready frequency-word write handshake
//   cfg_ch, cfg_fcw     target channel and new frequency control word
//   phase_vld           phase_ch/phase_out/phase_wrap valid this cycle
//   phase_ch            channel of the result
//   phase_out           updated phase of phase_ch
//   phase_wrap          carry out of the phase addition
//   busy                scheduler not in IDLE
module nco_acc_sched
  import nco_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [W-1:0]           cfg_fcw,
  output logic                   phase_vld,
  output logic [$clog2(NCH)-1:0] phase_ch,
  output logic [W-1:0]           phase_out,
  output logic                   phase_wrap,
  output logic                   busy
);

  localparam int CW = $clog2(NCH);
  localparam int DW = (ADD_LAT > 2) ? $clog2(ADD_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(ADD_LAT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] slot_q, slot_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [W-1:0]  phase_q [NCH];
  logic [W-1:0]  phase_d [NCH];
  logic [W-1:0]  fcw_q [NCH];
  logic [W-1:0]  fcw_d [NCH];
  logic          shadow_vld_q, shadow_vld_d;
  logic [CW-1:0] shadow_ch_q, shadow_ch_d;
  logic [W-1:0]  shadow_fcw_q, shadow_fcw_d;

  logic          issue;
  logic          cfg_acc;
  logic          shadow_apply;
  logic          wb_vld;
  logic [CW-1:0] wb_tag;
  logic [W-1:0]  wb_sum;

  function automatic logic [CW-1:0] next_slot(input logic [CW-1:0] s);
    if (s == CW'(NCH - 1)) return '0;
    return s + CW'(1);
  endfunction

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    drain_d      = drain_q;
    phase_d      = phase_q;
    fcw_d        = fcw_q;
    shadow_vld_d = shadow_vld_q;
    shadow_ch_d  = shadow_ch_q;
    shadow_fcw_d = shadow_fcw_q;
    issue        = 1'b0;
    shadow_apply = 1'b0;
    cfg_acc      = cfg_valid && !shadow_vld_q;

    if (clr) begin
      state_d = ST_IDLE;
      slot_d  = '0;
      drain_d = '0;
      for (int i = 0; i < NCH; i++) phase_d[i] = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) state_d = ST_RUN;
        end
        ST_RUN: begin
          // the cycle that sees en=0 still issues; DRAIN then covers exactly
          // the two results left in the adder
          issue  = 1'b1;
          slot_d = next_slot(slot_q);
          if (!en) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end
        end
        ST_DRAIN: begin
          if (en) state_d = ST_RUN;
          else if (drain_q == DRAIN_LAST) state_d = ST_IDLE;
          else drain_d = drain_q + DW'(1);
        end
        default: state_d = ST_IDLE;
      endcase
      // phase write-back lands on the edge that exposes the result
      if (wb_vld) phase_d[wb_tag] = wb_sum;
    end

    // the shadow word goes live on the edge before its channel is next read,
    // so that issue already adds the new word
    shadow_apply = shadow_vld_q &&
                   ((state_q == ST_IDLE) ||
                    ((state_d == ST_RUN) && (slot_d == shadow_ch_q)));
    if (shadow_apply) begin
      fcw_d[shadow_ch_q] = shadow_fcw_q;
      shadow_vld_d       = 1'b0;
    end
    if (cfg_acc) begin
      shadow_vld_d = 1'b1;
      shadow_ch_d  = cfg_ch;
      shadow_fcw_d = cfg_fcw;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      drain_q      <= '0;
      shadow_vld_q <= 1'b0;
      shadow_ch_q  <= '0;
      shadow_fcw_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        phase_q[i] <= '0;
        fcw_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      drain_q      <= drain_d;
      shadow_vld_q <= shadow_vld_d;
      shadow_ch_q  <= shadow_ch_d;
      shadow_fcw_q <= shadow_fcw_d;
      phase_q      <= phase_d;
      fcw_q        <= fcw_d;
    end
  end

  pipe_add #(
    .W  (W),
    .TW (CW)
  ) u_add (
    .clk     (clk),
    .rst     (rst),
    .flush   (clr),
    .in_vld  (issue),
    .in_tag  (slot_q),
    .in_a    (phase_q[slot_q]),
    .in_b    (fcw_q[slot_q]),
    .wb_vld  (wb_vld),
    .wb_tag  (wb_tag),
    .wb_sum  (wb_sum),
    .out_vld (phase_vld),
    .out_tag (phase_ch),
    .sum     (phase_out),
    .carry   (phase_wrap)
  );

  assign cfg_ready = !shadow_vld_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nco_acc_sched.sv
// Directed bench for nco_acc_sched: stimulus pushes hand-computed results
// (with the cycle they must appear in) into a queue; a monitor on the
// falling edge pops and compares every phase_vld pulse.
module tb_nco_acc_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_fcw = '0;
  logic        cfg_ready;
  logic        phase_vld;
  logic [1:0]  phase_ch;
  logic [15:0] phase_out;
  logic        phase_wrap;
  logic        busy;

  nco_acc_sched #(.NCH(4), .W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_fcw    (cfg_fcw),
    .phase_vld  (phase_vld),
    .phase_ch   (phase_ch),
    .phase_out  (phase_out),
    .phase_wrap (phase_wrap),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ch;
    int val;
    int wrap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (phase_vld === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: cyc %0d got ch %0d phase %0h wrap %0d, none required",
                 cyc, phase_ch, phase_out, phase_wrap);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc != mon_e.cyc || int'(phase_ch) != mon_e.ch ||
            int'(phase_out) != mon_e.val || int'(phase_wrap) != mon_e.wrap) begin
          errors++;
          $display("FAIL result: got cyc %0d ch %0d phase %0h wrap %0d, required cyc %0d ch %0d phase %0h wrap %0d",
                   cyc, phase_ch, phase_out, phase_wrap, mon_e.cyc, mon_e.ch, mon_e.val, mon_e.wrap);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic push(input int c, input int ch, input int v, input int w);
    exp_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.val  = v;
    e.wrap = w;
    exp_q.push_back(e);
  endtask

  task automatic cfg_write(input int ch, input int v);
    int k;
    k = 0;
    while (cfg_ready !== 1'b1 && k < 20) begin
      tick(1);
      k++;
    end
    chk("cfg_ready_wait", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_fcw   = 16'(v);
    tick(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int e;
    int k;
    // reset values
    tick(2);
    chk("rst_vld", phase_vld, 0);
    chk("rst_ch", phase_ch, 0);
    chk("rst_out", phase_out, 0);
    chk("rst_wrap", phase_wrap, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    rst = 1'b1;
    tick(2);

    cfg_write(0, 1);
    cfg_write(1, 2);
    cfg_write(2, 3);
    cfg_write(3, 4);

    // eight issues, two full rounds
    e = cyc;
    en = 1'b1;
    push(e+3, 0, 1, 0); push(e+4, 1, 2, 0); push(e+5, 2, 3, 0); push(e+6, 3, 4, 0);
    push(e+7, 0, 2, 0); push(e+8, 1, 4, 0); push(e+9, 2, 6, 0); push(e+10, 3, 8, 0);
    tick(8);
    en = 1'b0;
    tick(1); chk("t1_busy_drain0", busy, 1);
    tick(1); chk("t1_busy_drain1", busy, 1);
    tick(1); chk("t1_busy_idle", busy, 0);
    chk("t1_hold_vld", phase_vld, 0);
    chk("t1_hold_out", phase_out, 8);
    chk("t1_hold_ch", phase_ch, 3);
    tick(2);

    // stop mid-round, then resume at the next slot
    e = cyc;
    en = 1'b1;
    push(e+3, 0, 3, 0); push(e+4, 1, 6, 0);
    tick(2);
    en = 1'b0;
    tick(1); chk("t2_busy_drain0", busy, 1);
    tick(1); chk("t2_busy_drain1", busy, 1);
    tick(1); chk("t2_busy_idle", busy, 0);
    tick(2);
    e = cyc;
    en = 1'b1;
    push(e+3, 2, 9, 0); push(e+4, 3, 12, 0);
    tick(2);
    en = 1'b0;
    tick(4);

    // clr with two results in flight
    e = cyc;
    en = 1'b1;
    push(e+3, 0, 4, 0);
    tick(3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("t3_clr_vld", phase_vld, 0);
    chk("t3_clr_busy", busy, 0);
    push(e+7, 0, 1, 0); push(e+8, 1, 2, 0); push(e+9, 2, 3, 0); push(e+10, 3, 4, 0);
    tick(4);
    en = 1'b0;
    tick(5);

    // clr together with a cfg write, then ch0 wraps every other round
    chk("t4_ready_pre", cfg_ready, 1);
    clr = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch = 2'd0;
    cfg_fcw = 16'h8000;
    tick(1);
    clr = 1'b0;
    cfg_valid = 1'b0;
    chk("t4_cfg_taken_with_clr", cfg_ready, 0);
    tick(1);
    chk("t4_ready_post", cfg_ready, 1);
    e = cyc;
    en = 1'b1;
    push(e+3, 0, 'h8000, 0); push(e+4, 1, 2, 0);  push(e+5, 2, 3, 0);  push(e+6, 3, 4, 0);
    push(e+7, 0, 'h0000, 1); push(e+8, 1, 4, 0);  push(e+9, 2, 6, 0);  push(e+10, 3, 8, 0);
    push(e+11, 0, 'h8000, 0); push(e+12, 1, 6, 0); push(e+13, 2, 9, 0); push(e+14, 3, 12, 0);
    tick(12);
    en = 1'b0;
    tick(4);

    // cfg write of ch2 while ch0 issues: live before ch2's issue
    e = cyc;
    en = 1'b1;
    push(e+3, 0, 'h0000, 1); push(e+4, 1, 8, 0); push(e+5, 2, 'h19, 0); push(e+6, 3, 16, 0);
    tick(1);
    chk("t5_ready_open", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_ch = 2'd2;
    cfg_fcw = 16'h0010;
    tick(1);
    cfg_valid = 1'b0;
    chk("t5_ready_wait", cfg_ready, 0);
    tick(1);
    chk("t5_ready_back", cfg_ready, 1);
    tick(1);
    en = 1'b0;
    tick(5);

    // en returns during DRAIN: resume at the saved slot
    e = cyc;
    en = 1'b1;
    push(e+3, 0, 'h8000, 0); push(e+5, 1, 10, 0);
    tick(1);
    en = 1'b0;
    tick(1);
    en = 1'b1;
    chk("t6_busy_drain", busy, 1);
    tick(1);
    en = 1'b0;
    tick(1); chk("t6_busy_drain0", busy, 1);
    tick(1); chk("t6_busy_drain1", busy, 1);
    tick(1); chk("t6_busy_idle", busy, 0);
    tick(2);

    // asynchronous reset mid-RUN
    e = cyc;
    en = 1'b1;
    tick(2);
    rst = 1'b0;
    en = 1'b0;
    #1;
    chk("t7_rst_vld", phase_vld, 0);
    chk("t7_rst_ch", phase_ch, 0);
    chk("t7_rst_out", phase_out, 0);
    chk("t7_rst_wrap", phase_wrap, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_ready", cfg_ready, 1);
    tick(2);
    rst = 1'b1;
    tick(4);
    e = cyc;
    en = 1'b1;
    push(e+3, 0, 0, 0); push(e+4, 1, 0, 0); push(e+5, 2, 0, 0); push(e+6, 3, 0, 0);
    tick(4);
    en = 1'b0;

    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      tick(1);
      k++;
    end
    tick(3);
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
